// File: rtl/vdp_port_ctrl.sv
// CPU-side port controller for the TMS9918-style video block.
// Port decode, VRAM access sequencing, control registers, frame IRQ.
module vdp_port_ctrl #(
    parameter int ADDR_W = 14
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              port_cs,
    input  logic              port_a0,
    input  logic              port_wr,
    input  logic              port_rd,
    input  logic [7:0]        cpu_din,
    output logic [7:0]        cpu_dout,
    output logic              busy,
    output logic [ADDR_W-1:0] vram_addr,
    output logic              vram_wr,
    output logic              vram_rd,
    output logic [7:0]        vram_wdata,
    input  logic [7:0]        vram_rdata,
    input  logic              n_frame,
    output logic [1:0]        mode,
    output logic [13:0]       name_table_addr,
    output logic [13:0]       font_addr,
    output logic              video_on,
    output logic              n_int
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        CAPTURE
    } pf_state_t;

    pf_state_t         state;
    pf_state_t         state_nx;
    logic [7:0]        regs [8];
    logic [ADDR_W-1:0] addr_ptr;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        first;
    logic [7:0]        read_buf;
    logic              phase;
    logic              f_flag;
    logic              nf_q;
    logic              wr;
    logic              rd;
    logic              data_wr;
    logic              ctrl_wr;
    logic              data_rd;
    logic              stat_rd;
    logic              set_addr;
    logic              start;
    logic              fall;
    logic              unused_regs;

    // Strobes are dropped while a prefetch owns the VRAM port;
    // a write beats a simultaneous read.
    assign busy     = (state != IDLE);
    assign wr       = port_cs & port_wr & ~busy;
    assign rd       = port_cs & port_rd & ~busy & ~wr;
    assign data_wr  = wr & ~port_a0;
    assign ctrl_wr  = wr & port_a0;
    assign data_rd  = rd & ~port_a0;
    assign stat_rd  = rd & port_a0;
    assign set_addr = ctrl_wr & phase & ~cpu_din[7];
    assign start    = data_rd | (set_addr & ~cpu_din[6]);
    assign fall     = nf_q & ~n_frame;

    // The issue cycle drives the prefetch address, otherwise the last write.
    assign vram_addr = (state == ISSUE) ? addr_ptr : wr_addr;

    assign video_on        = regs[1][6];
    assign mode            = regs[1][4] ? 2'd0 : 2'd1;
    assign name_table_addr = {regs[2][3:0], 10'b0};
    assign font_addr       = {regs[4][2:0], 11'b0};

    assign unused_regs = ^{regs[0], regs[1][7], regs[1][3:0],
                           regs[2][7:4], regs[3], regs[4][7:3],
                           regs[5], regs[6], regs[7]};

    // Prefetch state register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Prefetch sequencing: one issue cycle, one capture cycle.
    always_comb begin
        state_nx = state;
        vram_rd  = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) state_nx = ISSUE;
            end
            ISSUE: begin
                vram_rd  = 1'b1;
                state_nx = CAPTURE;
            end
            CAPTURE: begin
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Port datapath, registers, address pointer and interrupt flag.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 8; i++) regs[i] <= '0;
            addr_ptr   <= '0;
            wr_addr    <= '0;
            first      <= '0;
            read_buf   <= '0;
            phase      <= 1'b0;
            f_flag     <= 1'b0;
            nf_q       <= 1'b1;
            n_int      <= 1'b1;
            cpu_dout   <= '0;
            vram_wr    <= 1'b0;
            vram_wdata <= '0;
        end else begin
            vram_wr <= data_wr;
            nf_q    <= n_frame;
            n_int   <= ~(f_flag & regs[1][5]);
            if (data_wr) begin
                wr_addr    <= addr_ptr;
                vram_wdata <= cpu_din;
                addr_ptr   <= addr_ptr + ADDR_W'(1);
                phase      <= 1'b0;
            end
            if (ctrl_wr) begin
                if (!phase) begin
                    first <= cpu_din;
                    phase <= 1'b1;
                end else begin
                    phase <= 1'b0;
                    if (cpu_din[7]) begin
                        regs[cpu_din[2:0]] <= first;
                    end else begin
                        addr_ptr <= ADDR_W'({cpu_din[5:0], first});
                    end
                end
            end
            if (data_rd) begin
                cpu_dout <= read_buf;
                phase    <= 1'b0;
            end
            if (stat_rd) begin
                cpu_dout <= {f_flag, 7'b0};
                phase    <= 1'b0;
            end
            if (state == CAPTURE) begin
                read_buf <= vram_rdata;
                addr_ptr <= addr_ptr + ADDR_W'(1);
            end
            if (fall) begin
                f_flag <= 1'b1;
            end else if (stat_rd) begin
                f_flag <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_vdp_port_ctrl.sv
// Bench for vdp_port_ctrl: directed plan plus random port traffic
// checked against a transaction-level model of the port rules.
module tb_vdp_port_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        port_cs;
    logic        port_a0;
    logic        port_wr;
    logic        port_rd;
    logic [7:0]  cpu_din;
    logic [7:0]  cpu_dout;
    logic        busy;
    logic [13:0] vram_addr;
    logic        vram_wr;
    logic        vram_rd;
    logic [7:0]  vram_wdata;
    logic [7:0]  vram_rdata;
    logic        n_frame;
    logic [1:0]  mode;
    logic [13:0] name_table_addr;
    logic [13:0] font_addr;
    logic        video_on;
    logic        n_int;

    int checks   = 0;
    int failures = 0;

    logic [7:0]  vmem [int];
    logic [7:0]  rmem [int];
    logic [7:0]  m_regs [8];
    logic [13:0] m_addr;
    logic [7:0]  m_first;
    logic [7:0]  m_rbuf;
    logic [7:0]  m_dout;
    bit          m_phase;
    bit          m_f;

    always #5 clk = ~clk;

    vdp_port_ctrl #(.ADDR_W(14)) dut (
        .clk             (clk),
        .reset           (reset),
        .port_cs         (port_cs),
        .port_a0         (port_a0),
        .port_wr         (port_wr),
        .port_rd         (port_rd),
        .cpu_din         (cpu_din),
        .cpu_dout        (cpu_dout),
        .busy            (busy),
        .vram_addr       (vram_addr),
        .vram_wr         (vram_wr),
        .vram_rd         (vram_rd),
        .vram_wdata      (vram_wdata),
        .vram_rdata      (vram_rdata),
        .n_frame         (n_frame),
        .mode            (mode),
        .name_table_addr (name_table_addr),
        .font_addr       (font_addr),
        .video_on        (video_on),
        .n_int           (n_int)
    );

    // Synchronous VRAM with one-cycle read latency.
    always @(posedge clk) begin
        if (vram_wr) vmem[int'(vram_addr)] = vram_wdata;
        if (vram_rd) begin
            vram_rdata <= vmem.exists(int'(vram_addr)) ?
                          vmem[int'(vram_addr)] : 8'h00;
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] ref_rd(input logic [13:0] a);
        return rmem.exists(int'(a)) ? rmem[int'(a)] : 8'h00;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_regs[i] = 8'h00;
        m_addr  = '0;
        m_first = '0;
        m_rbuf  = '0;
        m_dout  = '0;
        m_phase = 0;
        m_f     = 0;
    endtask

    task automatic settle();
        @(negedge clk);
        check("no_wr", vram_wr, 0);
        check("no_rd", vram_rd, 0);
        check("idle", busy, 0);
        check("dout_hold", cpu_dout, m_dout);
        check("n_int", n_int, !(m_f && m_regs[1][5]));
        check("video_on", video_on, m_regs[1][6]);
        check("mode", mode, m_regs[1][4] ? 0 : 1);
        check("name_tbl", name_table_addr, {m_regs[2][3:0], 10'b0});
        check("font", font_addr, {m_regs[4][2:0], 11'b0});
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        model_reset();
        check("rst_vaddr", vram_addr, 0);
        check("rst_wdata", vram_wdata, 0);
        check("rst_dout", cpu_dout, 0);
        settle();
    endtask

    // One port strobe; fe adds a coincident frame edge, junk fires
    // stray strobes while the resulting prefetch is busy.
    task automatic access(input bit a0, input bit w, input bit r,
                          input logic [7:0] d, input bit fe,
                          input bit junk);
        bit pf;
        pf = 0;
        @(negedge clk);
        port_cs = 1; port_a0 = a0; port_wr = w; port_rd = r;
        cpu_din = d;
        if (fe) n_frame = 0;
        @(negedge clk);
        port_cs = 0; port_wr = 0; port_rd = 0;
        if (fe) n_frame = 1;
        if (w && !a0) begin
            check("wr_pulse", vram_wr, 1);
            check("wr_addr", vram_addr, m_addr);
            check("wr_data", vram_wdata, d);
            rmem[int'(m_addr)] = d;
            m_addr++;
            m_phase = 0;
        end else if (w) begin
            if (!m_phase) begin
                m_first = d;
                m_phase = 1;
            end else begin
                m_phase = 0;
                if (d[7]) m_regs[d[2:0]] = m_first;
                else begin
                    m_addr = {d[5:0], m_first};
                    pf = !d[6];
                end
            end
        end else if (r && !a0) begin
            m_dout  = m_rbuf;
            m_phase = 0;
            pf      = 1;
            check("data_rd", cpu_dout, m_dout);
        end else if (r) begin
            m_dout  = {m_f, 7'b0};
            m_phase = 0;
            m_f     = 0;
            check("stat_rd", cpu_dout, m_dout);
        end
        if (fe) m_f = 1;
        if (pf) begin
            check("pf_busy1", busy, 1);
            check("pf_rd", vram_rd, 1);
            check("pf_addr", vram_addr, m_addr);
            if (junk) begin
                port_cs = 1;
                port_a0 = 1'($urandom_range(0, 1));
                port_wr = 1'($urandom_range(0, 1));
                port_rd = 1'($urandom_range(0, 1));
                cpu_din = 8'($urandom);
            end
            @(negedge clk);
            check("pf_busy2", busy, 1);
            check("pf_rd_once", vram_rd, 0);
            check("pf_no_wr", vram_wr, 0);
            @(negedge clk);
            port_cs = 0; port_wr = 0; port_rd = 0;
            check("pf_done", busy, 0);
            m_rbuf = ref_rd(m_addr);
            m_addr++;
        end
        settle();
    endtask

    task automatic frame();
        @(negedge clk);
        n_frame = 0;
        @(negedge clk);
        check("n_int_lag", n_int, !(m_f && m_regs[1][5]));
        m_f = 1;
        @(negedge clk);
        check("n_int_set", n_int, !m_regs[1][5]);
        n_frame = 1;
        settle();
    endtask

    task automatic ctrl2(input logic [7:0] a, input logic [7:0] b);
        access(1, 1, 0, a, 0, 0);
        access(1, 1, 0, b, 0, 0);
    endtask

    initial begin
        int op;
        reset = 0; port_cs = 0; port_a0 = 0; port_wr = 0; port_rd = 0;
        cpu_din = 0; n_frame = 1;
        model_reset();
        do_reset();
        check("rst_mode", mode, 1);
        check("rst_n_int", n_int, 1);

        ctrl2(8'h50, 8'h81);
        check("cfg_video_on", video_on, 1);
        check("cfg_mode", mode, 0);
        ctrl2(8'h0E, 8'h82);
        check("cfg_name", name_table_addr, 14'h3800);
        ctrl2(8'h01, 8'h84);
        check("cfg_font", font_addr, 14'h0800);

        ctrl2(8'hFE, 8'h7F);
        access(0, 1, 0, 8'hAA, 0, 0);
        access(0, 1, 0, 8'hBB, 0, 0);
        access(0, 1, 0, 8'hCC, 0, 0);

        ctrl2(8'h00, 8'h50);
        access(0, 1, 0, 8'h11, 0, 0);
        access(0, 1, 0, 8'h22, 0, 0);
        access(1, 1, 0, 8'h00, 0, 0);
        access(1, 1, 0, 8'h10, 0, 1);
        access(0, 0, 1, 8'h00, 0, 1);
        check("rd_11", cpu_dout, 8'h11);
        access(0, 0, 1, 8'h00, 0, 0);
        check("rd_22", cpu_dout, 8'h22);

        access(1, 1, 0, 8'h34, 0, 0);
        access(1, 0, 1, 8'h00, 0, 0);
        ctrl2(8'h00, 8'h40);
        access(0, 1, 0, 8'h5A, 0, 0);

        ctrl2(8'h20, 8'h81);
        frame();
        check("irq_low", n_int, 0);
        access(1, 0, 1, 8'h00, 0, 0);
        check("stat_80", cpu_dout, 8'h80);
        check("irq_clr", n_int, 1);
        access(1, 0, 1, 8'h00, 1, 0);
        access(1, 0, 1, 8'h00, 0, 0);
        check("stat_keep", cpu_dout, 8'h80);
        frame();
        ctrl2(8'h00, 8'h81);
        access(1, 0, 1, 8'h00, 0, 0);

        access(1, 1, 0, 8'h00, 0, 0);
        @(negedge clk);
        port_cs = 1; port_a0 = 1; port_wr = 1; cpu_din = 8'h10;
        @(negedge clk);
        port_cs = 0; port_wr = 0;
        check("abort_busy", busy, 1);
        reset = 0;
        @(negedge clk);
        reset = 1;
        model_reset();
        check("abort_idle", busy, 0);
        settle();
        access(0, 0, 1, 8'h00, 0, 0);

        for (int i = 0; i < 400; i++) begin
            op = $urandom_range(0, 7);
            case (op)
                0, 1: access(1, 1, 0, 8'($urandom), 0, 0);
                2: access(0, 1, 0, 8'($urandom), 0, 0);
                3: access(0, 0, 1, 8'h00, 0, 1'($urandom_range(0, 1)));
                4: access(1, 0, 1, 8'h00, $urandom_range(0, 3) == 0, 0);
                5: frame();
                6: access(0, 1, 1, 8'($urandom), 0, 0);
                default: access(1, 1, 1, 8'($urandom), 0, 0);
            endcase
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vdp_port_ctrl.md
Name: vdp_port_ctrl

Overview:
- CPU-side controller for the TMS9918-style text/graphics video block.
- Decodes the two VDP I/O ports (data, control) and sequences VRAM writes, prefetched reads and auto-incrementing addressing on the video RAM CPU port.
- Holds the 8 VDP control registers that configure the video block: mode, name/pattern table bases, display enable.
- Latches the frame interrupt into a status flag and drives the CPU interrupt line.

Parameters:
- ADDR_W, 14, VRAM address width; auto-increment wraps modulo 2^ADDR_W.

Ports:
- clk  input  1  system clock; same clock as the VRAM CPU port.
- reset  input  1  synchronous, active-low reset (0 = reset), sampled on rising clk.
- port_cs  input  1  VDP port select.
- port_a0  input  1  0 = data port, 1 = control/status port.
- port_wr  input  1  one-cycle write strobe, qualified by port_cs.
- port_rd  input  1  one-cycle read strobe, qualified by port_cs.
- cpu_din  input  8  CPU write data.
- cpu_dout  output  8  CPU read data, registered.
- busy  output  1  prefetch in progress; port strobes are ignored while high.
- vram_addr  output  ADDR_W  VRAM CPU-port address.
- vram_wr  output  1  VRAM write strobe.
- vram_rd  output  1  VRAM read strobe.
- vram_wdata  output  8  VRAM write data.
- vram_rdata  input  8  VRAM read data, valid 1 cycle after vram_rd.
- n_frame  input  1  active-low frame interrupt from the video block.
- mode  output  2  0 = 40-column text, 1 = 32-column graphics.
- name_table_addr  output  14  name table base.
- font_addr  output  14  pattern/font base.
- video_on  output  1  display enable.
- n_int  output  1  active-low CPU interrupt.

Behaviour:
- Reset (reset=0 at clk edge) clears:
  - R0..R7, addr_ptr, first-byte latch, phase flag, read_buf, F flag, FSM to IDLE.
  - Resulting outputs: cpu_dout=0, vram_wr=0, vram_rd=0, vram_wdata=0, vram_addr=0, busy=0, n_int=1, video_on=0, mode=1, name_table_addr=0, font_addr=0.
  - Reset mid-prefetch aborts it; read_buf stays 0.
- Access decode:
  - wr = port_cs & port_wr & !busy; rd = port_cs & port_rd & !busy.
  - If wr and rd are asserted together, the write wins and the read is dropped.
- Control write, phase=0: latch cpu_din as the first byte; phase<=1.
- Control write, phase=1: phase<=0, then decode cpu_din:
  - bit7=1: register write; R[cpu_din[2:0]] <= first byte.
  - bit7=0: addr_ptr <= {cpu_din[5:0], first}.
  - bit7=0 and bit6=0: additionally start a prefetch (read setup).
- Data write:
  - Next cycle: vram_wr=1 for exactly 1 cycle, vram_addr=addr_ptr, vram_wdata=cpu_din.
  - addr_ptr increments by 1 (3FFF -> 0000).
  - Clears phase. read_buf is not updated.
- Data read:
  - cpu_dout<=read_buf on the next cycle; clears phase; starts a prefetch.
- Status read (control port):
  - Next cycle: cpu_dout <= {F,7'b0}.
  - F<=0 and phase<=0.
  - If a new frame edge arrives in the same cycle, the set wins and F stays 1.
- Prefetch FSM:
  - IDLE -> ISSUE: vram_rd=1, vram_addr=addr_ptr, busy=1.
  - ISSUE -> CAPTURE: read_buf<=vram_rdata, addr_ptr+1 with wrap, busy=1.
  - CAPTURE -> IDLE.
  - busy is high for exactly 2 cycles, starting the cycle after the triggering strobe.
  - Strobes arriving while busy are discarded with no state change.
- cpu_dout holds its value between reads; it is unaffected by writes.
- Register mapping; unused register bits are stored but have no output effect:
  - video_on = R1[6]; int_en = R1[5].
  - mode = R1[4] ? 0 : 1.
  - name_table_addr = {R2[3:0],10'b0}.
  - font_addr = {R4[2:0],11'b0}.
- Interrupt:
  - n_frame is registered; a falling edge (1 -> 0) sets F.
  - n_int = !(F & int_en), registered, so it updates 1 cycle after F/int_en change.
  - Clearing int_en releases n_int without clearing F.

Test Plan:
- Reset state: hold reset=0 for 3 clk, release -> all outputs at reset values; mode=1, n_int=1.
- Register config:
  - Control writes 0x50,0x81 -> R1=0x50: video_on=1, mode=0, int_en=0.
  - Control writes 0x0E,0x82 -> name_table_addr=0x3800.
  - Control writes 0x01,0x84 -> font_addr=0x0800.
- Write burst with wrap:
  - Control writes 0xFE,0x7F (addr 0x3FFE, write setup).
  - Then data writes AA,BB,CC -> vram_wr pulses at 0x3FFE, 0x3FFF, 0x0000 with those data; no vram_rd.
- Read prefetch:
  - Preload VRAM[0x1000]=0x11 and VRAM[0x1001]=0x22.
  - Control writes 0x00,0x10 -> vram_rd at 0x1000, busy high 2 cycles.
  - Data read -> cpu_dout=0x11, new prefetch at 0x1001.
  - Next data read -> cpu_dout=0x22.
  - A strobe issued while busy=1 is ignored.
- Phase reset: control write 0x34, then status read, then control writes 0x00,0x40 -> addr_ptr=0x0000, not 0x0034.
- Interrupt:
  - With R1=0x20, drive n_frame low -> n_int=0 two cycles later.
  - Status read -> cpu_dout=0x80 and n_int returns to 1.
  - Status read coincident with a new falling edge -> F stays 1 and the next status read returns 0x80.
